// File: rtl/sync_fifo_ctrl.sv
// FIFO controller that drives an external dual-port storage core with a registered read port.
// It presents a first-word-fall-through valid/ready interface and carries no data itself.
module sync_fifo_ctrl #(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int CNT_W        = $clog2(DEPTH + 2)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              full_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0]  AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [ADDR_W-1:0] wptr_reg, wptr_next;
  logic [ADDR_W-1:0] rptr_reg, rptr_next;
  logic [CNT_W-1:0]  mem_cnt_reg, mem_cnt_next;
  logic              out_vld_reg, out_vld_next;
  logic              wr_fire, rd_fire;

  // mem_cnt_reg excludes this cycle's write, so a slot is never read while being written.
  assign in_ready_o = (mem_cnt_reg != DEPTH_CNT);
  assign wr_fire    = in_valid_i && in_ready_o && !flush_i && !rst_i;
  assign rd_fire    = (mem_cnt_reg != '0) && (!out_vld_reg || out_ready_i) && !flush_i && !rst_i;

  assign mem_we_o    = wr_fire;
  assign mem_waddr_o = wptr_reg;
  assign mem_re_o    = rd_fire;
  assign mem_raddr_o = rptr_reg;
  assign out_valid_o = out_vld_reg;
  assign count_o     = mem_cnt_reg + CNT_W'(out_vld_reg);
  assign empty_o     = (count_o == '0);
  assign afull_o     = (count_o >= AFULL_CNT);
  assign full_o      = !in_ready_o;

  always_comb begin
    wptr_next    = wptr_reg;
    rptr_next    = rptr_reg;
    mem_cnt_next = mem_cnt_reg;
    out_vld_next = out_vld_reg;
    if (flush_i) begin
      wptr_next    = '0;
      rptr_next    = '0;
      mem_cnt_next = '0;
      out_vld_next = 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct.
      if (wr_fire) begin
        wptr_next = (wptr_reg == LAST_ADDR) ? '0 : wptr_reg + ADDR_W'(1);
      end
      if (rd_fire) begin
        rptr_next = (rptr_reg == LAST_ADDR) ? '0 : rptr_reg + ADDR_W'(1);
      end
      mem_cnt_next = mem_cnt_reg + CNT_W'(wr_fire) - CNT_W'(rd_fire);
      if (rd_fire) begin
        out_vld_next = 1'b1;
      end else if (out_ready_i) begin
        out_vld_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      mem_cnt_reg <= '0;
      out_vld_reg <= 1'b0;
    end else begin
      wptr_reg    <= wptr_next;
      rptr_reg    <= rptr_next;
      mem_cnt_reg <= mem_cnt_next;
      out_vld_reg <= out_vld_next;
    end
  end

  a_no_write_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_we_o && (mem_cnt_reg == DEPTH_CNT)));
  a_no_read_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_re_o && (mem_cnt_reg == '0)));
  a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (count_o <= MAX_CNT));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboarded bench for sync_fifo_ctrl with a storage-core model and a queue-level reference.
// It combines directed latency, full, flush and reset cases with a randomized stream.
module tb_sync_fifo_ctrl;
  localparam int DEPTH        = 5;
  localparam int AFULL_THRESH = DEPTH - 2;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int CNT_W        = $clog2(DEPTH + 2);

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic in_ready, out_valid, mem_we, mem_re, empty, afull, full;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [CNT_W-1:0]  count;

  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] mem [2**ADDR_W];

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;
  int exp_q[$];

  // Reference state: storage occupancy, output slot, running write/read totals.
  int m_st = 0;
  bit m_ov = 1'b0;
  int m_wr_n = 0;
  int m_rd_n = 0;
  int next_tag = 0;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL_THRESH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .mem_we_o(mem_we), .mem_waddr_o(waddr),
    .mem_re_o(mem_re), .mem_raddr_o(raddr),
    .count_o(count), .empty_o(empty), .afull_o(afull), .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wdata = 16'(next_tag);
  endtask

  // Storage core: registered, read-enable-gated read port.
  always @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
    if (mem_re) rdata <= mem[raddr];
  end

  always @(negedge clk) begin : model
    bit m_wr, m_rd, m_pop;
    m_wr  = in_valid && (m_st != DEPTH) && !rst && !flush;
    m_rd  = (m_st != 0) && (!m_ov || out_ready) && !rst && !flush;
    m_pop = m_ov && out_ready && !rst && !flush;
    if (checking) begin
      check("in_ready", int'(in_ready), int'(m_st != DEPTH));
      check("full", int'(full), int'(m_st == DEPTH));
      check("out_valid", int'(out_valid), int'(m_ov));
      check("count", int'(count), m_st + int'(m_ov));
      check("empty", int'(empty), int'((m_st + int'(m_ov)) == 0));
      check("afull", int'(afull), int'((m_st + int'(m_ov)) >= AFULL_THRESH));
      check("mem_we", int'(mem_we), int'(m_wr));
      check("mem_re", int'(mem_re), int'(m_rd));
      check("waddr", int'(waddr), m_wr_n % DEPTH);
      check("raddr", int'(raddr), m_rd_n % DEPTH);
    end
    if (rst || flush) begin
      m_st = 0; m_ov = 1'b0; m_wr_n = 0; m_rd_n = 0;
      exp_q.delete();
    end else begin
      if (m_wr) begin
        exp_q.push_back(int'(wdata));
        next_tag++;
        m_wr_n++;
      end
      if (m_rd) m_rd_n++;
      m_st = m_st + int'(m_wr) - int'(m_rd);
      if (m_pop) m_ov = 1'b0;
      if (m_rd) m_ov = 1'b1;
    end
  end

  always @(negedge clk) begin : monitor
    if (checking && !rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        check("data", int'(rdata), exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nw;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; wdata = '0;
    tick();
    checking = 1'b1;
    #1 check("rst_we", int'(mem_we), 0);
    tick(); rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_waddr", int'(waddr), 0);
    check("rst_raddr", int'(raddr), 0);

    // Single write latency with the consumer ready.
    tick(); in_valid = 1'b1; out_ready = 1'b1;
    #1 check("lat_c0_we", int'(mem_we), 1); check("lat_c0_waddr", int'(waddr), 0);
    tick(); in_valid = 1'b0;
    #1 check("lat_c1_re", int'(mem_re), 1); check("lat_c1_raddr", int'(raddr), 0);
    check("lat_c1_count", int'(count), 1);
    tick();
    #1 check("lat_c2_valid", int'(out_valid), 1); check("lat_c2_count", int'(count), 1);
    tick();
    #1 check("lat_c3_valid", int'(out_valid), 0); check("lat_c3_count", int'(count), 0);

    // Fill to capacity under backpressure.
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    nw = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      #1;
      if (mem_we) begin
        check("fill_waddr", int'(waddr), nw % DEPTH);
        nw++;
      end
      tick();
    end
    check("fill_writes", nw, DEPTH + 1);
    #1;
    check("fill_count", int'(count), DEPTH + 1);
    check("fill_full", int'(full), 1);
    check("fill_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    #1 check("pop_ready_same", int'(in_ready), 0);
    tick(); out_ready = 1'b0;
    #1 check("pop_ready_next", int'(in_ready), 1); check("pop_count", int'(count), DEPTH);
    check("refill_we", int'(mem_we), 1);
    tick();
    #1 check("refill_count", int'(count), DEPTH + 1); check("refill_in_ready", int'(in_ready), 0);

    // Randomized stream with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
    end
    tick(); in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) tick();
    #1;
    check("drain_count", int'(count), 0);
    check("drain_empty", int'(empty), 1);
    check("drain_queue", exp_q.size(), 0);

    // Flush at count 3 while a write is offered.
    tick(); in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick(); flush = 1'b1;
    #1 check("flush_pre_count", int'(count), 3); check("flush_we", int'(mem_we), 0);
    check("flush_re", int'(mem_re), 0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    #1 check("flush_count", int'(count), 0); check("flush_valid", int'(out_valid), 0);
    check("flush_waddr", int'(waddr), 0); check("flush_raddr", int'(raddr), 0);
    tick(); in_valid = 1'b1;
    #1 check("post_flush_we", int'(mem_we), 1); check("post_flush_waddr", int'(waddr), 0);
    tick(); in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1 check("final_count", int'(count), 0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
